mul_iter_stage: RTL and testbench
=================================

# mul_iter_stage

Iterative signed multiplier that forms the first stage of the MUL pipeline. Accepts a multiply request with both operands from decode, computes the 32x32 signed product over multiple cycles with a shift-add datapath, detects overflow, and emits a single-cycle result packet into the downstream pass-through `mul_stage` chain. Back-pressures decode with `mul_ready` while busy.

## Interface
- No parameters; widths come from `soc.vh` (`REG_FILE_DATA_WIDTH` = 32).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `thread_id_in`  in  `THR_PER_CORE_WIDTH`  requesting thread.
- `instr_valid_in`  in  1  request valid.
- `instr_id_in`  in  `ROB_ID_RANGE`  ROB tag.
- `program_counter_in`  in  `PC_WIDTH`  instruction PC.
- `dest_reg_in`  in  `REG_FILE_ADDR_RANGE`  destination register.
- `src1_data_in`, `src2_data_in`  in  `REG_FILE_DATA_RANGE`  signed multiplicand, multiplier.
- `xcpt_fetch_in`  in  `fetch_xcpt_t`; `xcpt_decode_in`  in  `decode_xcpt_t`  upstream exceptions.
- `flush_mul`  in  1  kill in-flight operation.
- `mul_ready`  out  1  stage can accept a request this cycle.
- `thread_id_out`, `instr_valid_out`, `instr_id_out`, `program_counter_out`, `dest_reg_out`  out  as inputs  registered request fields.
- `data_result_out`  out  `REG_FILE_DATA_RANGE`  low 32 bits of signed product.
- `xcpt_fetch_out`, `xcpt_decode_out`  out  forwarded exceptions.
- `xcpt_mul_out`  out  `mul_xcpt_t`  `xcpt_overflow` set on overflow; other fields zero.

## Operation
- FSM states: IDLE, BUSY, DONE. `mul_ready` = (state==IDLE) || (state==DONE).
- Accept: `instr_valid_in && mul_ready && !flush_mul` latches all request fields, |src1| into 64-bit multiplicand reg, |src2| into 32-bit multiplier reg, result sign = sign1 XOR sign2, clears accumulator and 5-bit counter.
- Accept with any upstream exception valid (fetch or decode): next state DONE directly, result 0, `xcpt_overflow` 0, exceptions forwarded.
- Accept otherwise: next state BUSY.
- BUSY, per cycle: if multiplier[0], accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. Leave to DONE after the cycle with counter==31.
- Final result: accumulator negated (two's complement, 64-bit) if sign set. `data_result_out` = low 32 bits.
- Overflow: `xcpt_overflow` = 1 iff full 64-bit signed product outside [-2^31, 2^31-1] (magnitude > 2^31-1 when positive, > 2^31 when negative). Result still written as low 32 bits.
- DONE: `instr_valid_out` = 1 for exactly this one cycle. Next state BUSY/DONE if a new request is accepted this cycle, else IDLE.
- `flush_mul`: highest priority; state -> IDLE next cycle, no output valid, same-cycle request not accepted. Flush during DONE suppresses `instr_valid_out` that cycle.
- Downstream never stalls; no output back-pressure.

## Timing
- Reset: state IDLE, `mul_ready` 1, all outputs 0 (`instr_valid_out` 0, exception structs all-zero).
- All outputs registered except `mul_ready` (decoded from state) and `instr_valid_out` (state==DONE && !flush_mul).
- Request accepted at edge E: BUSY cycles E+1..E+32, `instr_valid_out` high in cycle E+33 (33-cycle latency, macro off).
- Exception bypass: valid out in cycle E+1.
- Back-to-back: request accepted in DONE cycle, no bubble; output fields of the finishing op remain stable through that DONE cycle.
- Output data fields hold last value outside DONE; only `instr_valid_out` qualifies them.

## Configuration
- `MUL_EARLY_TERM_EN` defined: BUSY also exits to DONE after any cycle where the shifted multiplier becomes zero; minimum latency 2 (multiplier 0 or 1), result bit-identical.
- Undefined: fixed 32 BUSY cycles for every non-exception request.

## Test plan
- 7 * -3, macro off -> `data_result_out` 0xFFFFFFEB, overflow 0, valid exactly in cycle E+33, `mul_ready` low E+1..E+32.
- 0x00010000 * 0x00010000 -> result 0x00000000, `xcpt_overflow` 1; 0x80000000 * 1 -> 0x80000000, overflow 0; 0x80000000 * 0xFFFFFFFF -> 0x80000000, overflow 1.
- Request with `xcpt_decode_in` valid -> valid in E+1, result 0, decode exception forwarded, overflow 0.
- `flush_mul` at cycle E+10 -> no `instr_valid_out`, `mul_ready` 1 at E+11; new request 2*3 then yields 6.
- Second request (5*5) presented in DONE cycle of first (2*3) -> accepted, outputs 6 then 25, no idle bubble.
- Macro on: 123456 * 1 -> 123456 valid in E+2; -4 * 8 -> 0xFFFFFFE0 valid in E+5; reset asserted mid-BUSY -> all outputs 0, `mul_ready` 1 immediately.

Source files
------------

// File: rtl/mul_iter_stage.sv
// Iterative 32x32 signed shift-add multiplier, first stage of the MUL pipe.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
package mul_iter_pkg;
    localparam int THR_PER_CORE_WIDTH  = 2;
    localparam int ROB_ID_WIDTH        = 4;
    localparam int PC_WIDTH            = 32;
    localparam int REG_FILE_ADDR_WIDTH = 5;
    localparam int REG_FILE_DATA_WIDTH = 32;

    typedef struct packed {
        logic                xcpt_bus_error;
        logic                xcpt_itlb_miss;
        logic [PC_WIDTH-1:0] xcpt_addr_val;
    } fetch_xcpt_t;

    typedef struct packed {
        logic xcpt_illegal_instr;
        logic xcpt_pc_misaligned;
    } decode_xcpt_t;

    typedef struct packed {
        logic xcpt_overflow;
    } mul_xcpt_t;
endpackage

module mul_iter_stage
    import mul_iter_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [THR_PER_CORE_WIDTH-1:0]  thread_id_in,
    input  logic                           instr_valid_in,
    input  logic [ROB_ID_WIDTH-1:0]        instr_id_in,
    input  logic [PC_WIDTH-1:0]            program_counter_in,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dest_reg_in,
    input  logic [REG_FILE_DATA_WIDTH-1:0] src1_data_in,
    input  logic [REG_FILE_DATA_WIDTH-1:0] src2_data_in,
    input  fetch_xcpt_t                    xcpt_fetch_in,
    input  decode_xcpt_t                   xcpt_decode_in,
    input  logic                           flush_mul,
    output logic                           mul_ready,
    output logic [THR_PER_CORE_WIDTH-1:0]  thread_id_out,
    output logic                           instr_valid_out,
    output logic [ROB_ID_WIDTH-1:0]        instr_id_out,
    output logic [PC_WIDTH-1:0]            program_counter_out,
    output logic [REG_FILE_ADDR_WIDTH-1:0] dest_reg_out,
    output logic [REG_FILE_DATA_WIDTH-1:0] data_result_out,
    output fetch_xcpt_t                    xcpt_fetch_out,
    output decode_xcpt_t                   xcpt_decode_out,
    output mul_xcpt_t                      xcpt_mul_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e state_q, state_d;

    logic [THR_PER_CORE_WIDTH-1:0]  thr_q;
    logic [ROB_ID_WIDTH-1:0]        id_q;
    logic [PC_WIDTH-1:0]            pc_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] dst_q;
    fetch_xcpt_t                    fx_q;
    decode_xcpt_t                   dx_q;

    logic [63:0] mcand_q, acc_q;
    logic [31:0] mplier_q;
    logic [4:0]  cnt_q;
    logic        sign_q;

    logic [THR_PER_CORE_WIDTH-1:0]  thr_out_q;
    logic [ROB_ID_WIDTH-1:0]        id_out_q;
    logic [PC_WIDTH-1:0]            pc_out_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] dst_out_q;
    logic [31:0]                    res_q;
    fetch_xcpt_t                    fx_out_q;
    decode_xcpt_t                   dx_out_q;
    logic                           ovf_q;

    logic        accept, up_xcpt, last, step;
    logic [31:0] a_mag, b_mag, mplier_sh;
    logic [63:0] acc_sum, prod;

    assign mul_ready = (state_q == IDLE) || (state_q == DONE);
    assign accept    = instr_valid_in && mul_ready && !flush_mul;
    assign up_xcpt   = xcpt_fetch_in.xcpt_bus_error
                     | xcpt_fetch_in.xcpt_itlb_miss
                     | xcpt_decode_in.xcpt_illegal_instr
                     | xcpt_decode_in.xcpt_pc_misaligned;

    assign a_mag = src1_data_in[31] ? -src1_data_in : src1_data_in;
    assign b_mag = src2_data_in[31] ? -src2_data_in : src2_data_in;

    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign mplier_sh = mplier_q >> 1;
    assign prod      = sign_q ? -acc_sum : acc_sum;
    assign step      = (state_q == BUSY) && !flush_mul;

`ifdef MUL_EARLY_TERM_EN
    assign last = (cnt_q == 5'd31) || (mplier_sh == 32'd0);
`else
    assign last = (cnt_q == 5'd31);
`endif

    always_comb begin
        state_d = state_q;
        if (flush_mul) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                BUSY:    state_d = last ? DONE : BUSY;
                default: begin
                    if (accept) state_d = up_xcpt ? DONE : BUSY;
                    else        state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            thr_q     <= '0;
            id_q      <= '0;
            pc_q      <= '0;
            dst_q     <= '0;
            fx_q      <= '0;
            dx_q      <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            thr_out_q <= '0;
            id_out_q  <= '0;
            pc_out_q  <= '0;
            dst_out_q <= '0;
            res_q     <= '0;
            fx_out_q  <= '0;
            dx_out_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                thr_q    <= thread_id_in;
                id_q     <= instr_id_in;
                pc_q     <= program_counter_in;
                dst_q    <= dest_reg_in;
                fx_q     <= xcpt_fetch_in;
                dx_q     <= xcpt_decode_in;
                mcand_q  <= {32'd0, a_mag};
                mplier_q <= b_mag;
                sign_q   <= src1_data_in[31] ^ src2_data_in[31];
                acc_q    <= '0;
                cnt_q    <= '0;
                // Exception requests skip the datapath and publish at once.
                if (up_xcpt) begin
                    thr_out_q <= thread_id_in;
                    id_out_q  <= instr_id_in;
                    pc_out_q  <= program_counter_in;
                    dst_out_q <= dest_reg_in;
                    fx_out_q  <= xcpt_fetch_in;
                    dx_out_q  <= xcpt_decode_in;
                    res_q     <= '0;
                    ovf_q     <= 1'b0;
                end
            end else if (step) begin
                acc_q    <= acc_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_sh;
                cnt_q    <= cnt_q + 5'd1;
                if (last) begin
                    thr_out_q <= thr_q;
                    id_out_q  <= id_q;
                    pc_out_q  <= pc_q;
                    dst_out_q <= dst_q;
                    fx_out_q  <= fx_q;
                    dx_out_q  <= dx_q;
                    res_q     <= prod[31:0];
                    // In range only if bits 63..31 are a pure sign extension.
                    ovf_q     <= !((&prod[63:31]) || !(|prod[63:31]));
                end
            end
        end
    end

    assign instr_valid_out            = (state_q == DONE) && !flush_mul;
    assign thread_id_out              = thr_out_q;
    assign instr_id_out               = id_out_q;
    assign program_counter_out        = pc_out_q;
    assign dest_reg_out               = dst_out_q;
    assign data_result_out            = res_q;
    assign xcpt_fetch_out             = fx_out_q;
    assign xcpt_decode_out            = dx_out_q;
    assign xcpt_mul_out.xcpt_overflow = ovf_q;
endmodule

// File: tb/tb_mul_iter_stage.sv
// Self-checking bench for mul_iter_stage: vector table, hand sequences,
// and random operands against an arithmetic reference model.
module tb_mul_iter_stage;
    import mul_iter_pkg::*;

    logic                           clock;
    logic                           reset;
    logic [THR_PER_CORE_WIDTH-1:0]  thread_id_in;
    logic                           instr_valid_in;
    logic [ROB_ID_WIDTH-1:0]        instr_id_in;
    logic [PC_WIDTH-1:0]            program_counter_in;
    logic [REG_FILE_ADDR_WIDTH-1:0] dest_reg_in;
    logic [31:0]                    src1_data_in, src2_data_in;
    fetch_xcpt_t                    xcpt_fetch_in;
    decode_xcpt_t                   xcpt_decode_in;
    logic                           flush_mul;
    logic                           mul_ready;
    logic [THR_PER_CORE_WIDTH-1:0]  thread_id_out;
    logic                           instr_valid_out;
    logic [ROB_ID_WIDTH-1:0]        instr_id_out;
    logic [PC_WIDTH-1:0]            program_counter_out;
    logic [REG_FILE_ADDR_WIDTH-1:0] dest_reg_out;
    logic [31:0]                    data_result_out;
    fetch_xcpt_t                    xcpt_fetch_out;
    decode_xcpt_t                   xcpt_decode_out;
    mul_xcpt_t                      xcpt_mul_out;

    mul_iter_stage dut (
        .clock               (clock),
        .reset               (reset),
        .thread_id_in        (thread_id_in),
        .instr_valid_in      (instr_valid_in),
        .instr_id_in         (instr_id_in),
        .program_counter_in  (program_counter_in),
        .dest_reg_in         (dest_reg_in),
        .src1_data_in        (src1_data_in),
        .src2_data_in        (src2_data_in),
        .xcpt_fetch_in       (xcpt_fetch_in),
        .xcpt_decode_in      (xcpt_decode_in),
        .flush_mul           (flush_mul),
        .mul_ready           (mul_ready),
        .thread_id_out       (thread_id_out),
        .instr_valid_out     (instr_valid_out),
        .instr_id_out        (instr_id_out),
        .program_counter_out (program_counter_out),
        .dest_reg_out        (dest_reg_out),
        .data_result_out     (data_result_out),
        .xcpt_fetch_out      (xcpt_fetch_out),
        .xcpt_decode_out     (xcpt_decode_out),
        .xcpt_mul_out        (xcpt_mul_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [THR_PER_CORE_WIDTH-1:0]  e_thr;
    logic [ROB_ID_WIDTH-1:0]        e_id;
    logic [PC_WIDTH-1:0]            e_pc;
    logic [REG_FILE_ADDR_WIDTH-1:0] e_dst;
    decode_xcpt_t                   e_dx;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          dx;
        logic [31:0] res;
        bit          ovf;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: full-width signed product and its 32-bit range test.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit o);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        r  = p[31:0];
        o  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    // Cycles from the accepting edge to the cycle carrying the result.
    function automatic int lat_of(input logic [31:0] b, input bit xc);
        logic [31:0] m;
        int n;
        if (xc) return 1;
`ifdef MUL_EARLY_TERM_EN
        m = b[31] ? -b : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n + 1;
`else
        m = b;
        n = 32 + int'(m[0] & 1'b0);
        return n + 1;
`endif
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input bit dx);
        decode_xcpt_t d;
        d = '0;
        d.xcpt_illegal_instr = dx;
        e_thr = THR_PER_CORE_WIDTH'($urandom);
        e_id  = ROB_ID_WIDTH'($urandom);
        e_pc  = $urandom;
        e_dst = REG_FILE_ADDR_WIDTH'($urandom);
        e_dx  = d;
        chk("ready_before_issue", 64'(mul_ready), 64'd1);
        thread_id_in       = e_thr;
        instr_id_in        = e_id;
        program_counter_in = e_pc;
        dest_reg_in        = e_dst;
        src1_data_in       = a;
        src2_data_in       = b;
        xcpt_decode_in     = d;
        instr_valid_in     = 1'b1;
        @(posedge clock);
        #1;
        instr_valid_in = 1'b0;
        xcpt_decode_in = '0;
        src1_data_in   = $urandom;
        src2_data_in   = $urandom;
    endtask

    // Returns with the bench at the negedge of the DONE cycle.
    task automatic check_op(input string name, input logic [31:0] er,
                            input bit eo, input int elat);
        int  got;
        bit  busy_ok;
        got = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (instr_valid_out) begin
                got = k;
                break;
            end
            if (mul_ready) busy_ok = 1'b0;
        end
        chk({name, "_latency"}, 64'(got), 64'(elat));
        chk({name, "_ready_low_busy"}, 64'(busy_ok), 64'd1);
        chk({name, "_result"}, 64'(data_result_out), 64'(er));
        chk({name, "_ovf"}, 64'(xcpt_mul_out.xcpt_overflow), 64'(eo));
        chk({name, "_fields"},
            64'({thread_id_out, instr_id_out, program_counter_out, dest_reg_out}),
            64'({e_thr, e_id, e_pc, e_dst}));
        chk({name, "_dxcpt"}, 64'(xcpt_decode_out), 64'(e_dx));
        chk({name, "_fxcpt"}, 64'(xcpt_fetch_out), 64'd0);
    endtask

    logic [31:0] ra, rb, rr;
    bit          ro;
    int          seen;

    initial begin
        vt[0] = '{32'd7,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 1'b0};
        vt[1] = '{32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b1};
        vt[2] = '{32'h80000000, 32'd1,        1'b0, 32'h80000000, 1'b0};
        vt[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1};
        vt[4] = '{32'd3,        32'd4,        1'b1, 32'h00000000, 1'b0};
        vt[5] = '{32'd123456,   32'd1,        1'b0, 32'd123456,   1'b0};
        vt[6] = '{32'hFFFFFFFC, 32'd8,        1'b0, 32'hFFFFFFE0, 1'b0};
        vt[7] = '{32'h7FFFFFFF, 32'd2,        1'b0, 32'hFFFFFFFE, 1'b1};
        vt[8] = '{32'h40000000, 32'hFFFFFFFE, 1'b0, 32'h80000000, 1'b0};
        vt[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b0};

        reset              = 1'b0;
        instr_valid_in     = 1'b0;
        flush_mul          = 1'b0;
        thread_id_in       = '0;
        instr_id_in        = '0;
        program_counter_in = '0;
        dest_reg_in        = '0;
        src1_data_in       = '0;
        src2_data_in       = '0;
        xcpt_fetch_in      = '0;
        xcpt_decode_in     = '0;
        #12;
        chk("rst_ready", 64'(mul_ready), 64'd1);
        chk("rst_valid", 64'(instr_valid_out), 64'd0);
        chk("rst_data", 64'(data_result_out), 64'd0);
        chk("rst_xcpt", 64'({xcpt_fetch_out, xcpt_decode_out, xcpt_mul_out}), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].dx);
            check_op($sformatf("vec%0d", i), vt[i].res, vt[i].ovf,
                     lat_of(vt[i].b, vt[i].dx));
            @(negedge clock);
            chk($sformatf("vec%0d_idle_after", i), 64'(instr_valid_out), 64'd0);
        end

        // Flush in cycle E+10 kills the op and frees the stage at E+11.
        issue(32'd9, 32'd9, 1'b0);
        repeat (9) @(negedge clock);
        @(posedge clock);
        #1 flush_mul = 1'b1;
        @(posedge clock);
        #1 flush_mul = 1'b0;
        @(negedge clock);
        chk("flush_ready", 64'(mul_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (instr_valid_out) seen++;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        issue(32'd2, 32'd3, 1'b0);
        check_op("post_flush", 32'd6, 1'b0, lat_of(32'd3, 1'b0));

        // Second request accepted in the DONE cycle of the first.
        issue(32'd5, 32'd5, 1'b0);
        check_op("b2b", 32'd25, 1'b0, lat_of(32'd5, 1'b0));
        @(negedge clock);

        // Flush during DONE masks the valid.
        issue(32'd1, 32'd1, 1'b1);
        flush_mul = 1'b1;
        @(negedge clock);
        chk("flush_done_valid", 64'(instr_valid_out), 64'd0);
        @(posedge clock);
        #1 flush_mul = 1'b0;
        @(negedge clock);
        chk("flush_done_idle", 64'({instr_valid_out, mul_ready}), 64'b01);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = rb >> $urandom_range(31, 20);
            if (i % 4 == 2) ra = ra >> $urandom_range(31, 16);
            ref_mul(ra, rb, rr, ro);
            issue(ra, rb, 1'b0);
            check_op($sformatf("rnd%0d", i), rr, ro, lat_of(rb, 1'b0));
            if (i % 2 == 0) @(negedge clock);
        end
        @(negedge clock);

        // Asynchronous reset in the middle of an operation.
        issue(32'd5, 32'd7, 1'b0);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("arst_ready", 64'(mul_ready), 64'd1);
        chk("arst_outs",
            64'({instr_valid_out, thread_id_out, instr_id_out, dest_reg_out}), 64'd0);
        chk("arst_pc_data", {program_counter_out, data_result_out}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        issue(32'd6, 32'd7, 1'b0);
        check_op("after_arst", 32'd42, 1'b0, lat_of(32'd7, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
